// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrubber for a SECDED memory. Reads every word through the
// decoder, writes back corrected single-bit errors and logs double-bit errors.
module ecc_scrubber #(
    parameter int unsigned K          = 8,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned INTERVAL_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [INTERVAL_W-1:0] i_interval,
    output logic                  o_mem_req,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [K-1:0]          o_mem_wdata,
    input  logic                  i_mem_gnt,
    input  logic                  i_mem_rvalid,
    input  logic [K-1:0]          i_dec_data,
    input  logic                  i_dec_1bit_err,
    input  logic                  i_dec_2bit_err,
    input  logic                  i_db_clr,
    output logic [15:0]           o_sb_count,
    output logic [15:0]           o_db_count,
    output logic [ADDR_W-1:0]     o_db_addr,
    output logic                  o_db_valid,
    output logic                  o_busy,
    output logic                  o_pass_done
);

    localparam int unsigned       CNT_W     = 16;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT    = 3'd1,
        RD_REQ  = 3'd2,
        RD_WAIT = 3'd3,
        CHECK   = 3'd4,
        WR_REQ  = 3'd5
    } state_t;

    state_t                state;
    logic [INTERVAL_W-1:0] wait_cnt;
    logic                  sb_flag;
    logic                  db_flag;
    logic                  at_last;
    logic [ADDR_W-1:0]     addr_next;

    // o_mem_addr doubles as the scrub pointer; it only moves while no request is open
    assign at_last   = (o_mem_addr == LAST_ADDR);
    assign addr_next = at_last ? '0 : o_mem_addr + ADDR_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            sb_flag     <= 1'b0;
            db_flag     <= 1'b0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_sb_count  <= '0;
            o_db_count  <= '0;
            o_db_addr   <= '0;
            o_db_valid  <= 1'b0;
            o_busy      <= 1'b0;
            o_pass_done <= 1'b0;
        end else begin
            o_pass_done <= 1'b0;
            // a capture in CHECK below overrides a same-cycle clear
            if (i_db_clr) begin
                o_db_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (i_en) begin
                        state    <= WAIT;
                        wait_cnt <= i_interval;
                        o_busy   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (!i_en) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end else if (wait_cnt == '0) begin
                        state     <= RD_REQ;
                        o_mem_req <= 1'b1;
                        o_mem_we  <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - INTERVAL_W'(1);
                    end
                end
                RD_REQ: begin
                    if (i_mem_gnt) begin
                        state     <= RD_WAIT;
                        o_mem_req <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (i_mem_rvalid) begin
                        state       <= CHECK;
                        o_mem_wdata <= i_dec_data;
                        sb_flag     <= i_dec_1bit_err & ~i_dec_2bit_err;
                        db_flag     <= i_dec_2bit_err;
                    end
                end
                CHECK: begin
                    if (sb_flag) begin
                        if (o_sb_count != CNT_MAX) begin
                            o_sb_count <= o_sb_count + CNT_W'(1);
                        end
                        state     <= WR_REQ;
                        o_mem_req <= 1'b1;
                        o_mem_we  <= 1'b1;
                    end else begin
                        if (db_flag) begin
                            if (o_db_count != CNT_MAX) begin
                                o_db_count <= o_db_count + CNT_W'(1);
                            end
                            if (!o_db_valid || i_db_clr) begin
                                o_db_addr  <= o_mem_addr;
                                o_db_valid <= 1'b1;
                            end
                        end
                        o_mem_addr  <= addr_next;
                        o_pass_done <= at_last;
                        state       <= i_en ? WAIT : IDLE;
                        wait_cnt    <= i_interval;
                        o_busy      <= i_en;
                    end
                end
                WR_REQ: begin
                    if (i_mem_gnt) begin
                        o_mem_req   <= 1'b0;
                        o_mem_addr  <= addr_next;
                        o_pass_done <= at_last;
                        state       <= i_en ? WAIT : IDLE;
                        wait_cnt    <= i_interval;
                        o_busy      <= i_en;
                    end
                end
                default: begin
                    state     <= IDLE;
                    o_mem_req <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ecc_scrubber.sv
// tb_ecc_scrubber: randomized memory/decoder responder plus a word-by-word reference
// model of the scrub sequence, error counters and double-bit capture.
module tb_ecc_scrubber;

    localparam int unsigned K  = 8;
    localparam int unsigned AW = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned IW = 16;
    localparam int          TMO = 5000;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [K-1:0]  wdata;
    } txn_t;

    logic          clk, rst_n, en;
    logic [IW-1:0] interval;
    logic          mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [AW-1:0] mem_addr, db_addr;
    logic [K-1:0]  mem_wdata, dec_data;
    logic          dec_1bit_err, dec_2bit_err, db_clr;
    logic [15:0]   sb_count, db_count;
    logic          db_valid, busy, pass_done;

    ecc_scrubber #(.K(K), .ADDR_W(AW), .DEPTH(D), .INTERVAL_W(IW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_interval(interval),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_dec_data(dec_data),
        .i_dec_1bit_err(dec_1bit_err), .i_dec_2bit_err(dec_2bit_err), .i_db_clr(db_clr),
        .o_sb_count(sb_count), .o_db_count(db_count), .o_db_addr(db_addr),
        .o_db_valid(db_valid), .o_busy(busy), .o_pass_done(pass_done)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // responder configuration and observations
    int   gdly = 0, rdly = 0, clr_at = -1;
    bit   noise = 0, clr_force = 0;
    int   rd_cnt = 0, pd_cnt = 0, stab_err = 0;
    txn_t log_q[$];
    txn_t exp_q[$];
    int   grant_cyc[$];

    // memory image seen by the decoder; a writeback scrubs the 1-bit error
    logic [K-1:0] mem_data [D];
    bit           mem_e1 [D];
    bit           mem_e2 [D];

    // reference model state
    bit          m_e1 [D];
    int          m_addr = 0, m_pd = 0, m_dba = 0;
    logic [15:0] m_sb = 0, m_db = 0;
    bit          m_dbv = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // memory + decoder responder: all inputs change on the falling edge
    initial begin
        int   gc;
        bit   seen, rp, clr_next;
        int   rc, ra;
        txn_t first, cur;
        gc = 0; seen = 0; rp = 0; clr_next = 0; rc = 0; ra = 0; first = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; dec_data = '0;
        dec_1bit_err = 1'b0; dec_2bit_err = 1'b0; db_clr = 1'b0;
        forever begin
            @(negedge clk);
            mem_gnt      = 1'b0;
            mem_rvalid   = 1'b0;
            dec_data     = K'($urandom);
            dec_1bit_err = 1'b0;
            dec_2bit_err = 1'b0;
            db_clr       = clr_next | clr_force;
            clr_next     = 1'b0;
            if (pass_done === 1'b1) pd_cnt++;
            if (rp) begin
                if (rc == 0) begin
                    mem_rvalid   = 1'b1;
                    dec_data     = mem_data[ra];
                    dec_1bit_err = mem_e1[ra];
                    dec_2bit_err = mem_e2[ra];
                    rp = 1'b0;
                    if (ra == clr_at) clr_next = 1'b1;
                end else begin
                    rc--;
                end
            end
            if (rst_n !== 1'b1) begin
                seen = 0; gc = 0; rp = 0;
            end else if (mem_req === 1'b1) begin
                cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
                if (!seen) begin
                    first = cur;
                    seen  = 1'b1;
                end else if (cur !== first) begin
                    stab_err++;
                end
                if (gc >= gdly) begin
                    mem_gnt = 1'b1;
                    log_q.push_back(cur);
                    seen = 1'b0;
                    gc   = 0;
                    if (!cur.we) begin
                        rp = 1'b1; rc = rdly; ra = int'(cur.addr);
                        rd_cnt++;
                        grant_cyc.push_back(cyc);
                        if (noise) begin
                            mem_rvalid   = 1'b1;
                            dec_1bit_err = 1'b1;
                            dec_2bit_err = 1'b1;
                        end
                    end else begin
                        mem_e1[int'(cur.addr)] = 1'b0;
                    end
                end else begin
                    gc++;
                end
            end else begin
                seen = 1'b0;
                gc   = 0;
                if (noise) mem_gnt = 1'($urandom_range(0, 1));
            end
        end
    end

    // expected transactions for the next n words, straight from the scrub rules
    function automatic void predict(input int n, input int clr_a);
        txn_t t;
        for (int i = 0; i < n; i++) begin
            int a = m_addr;
            t.we = 1'b0; t.addr = AW'(a); t.wdata = '0;
            exp_q.push_back(t);
            if (mem_e2[a]) begin
                if (m_db != 16'hFFFF) m_db = m_db + 16'd1;
                if (!m_dbv || a == clr_a) begin
                    m_dbv = 1'b1;
                    m_dba = a;
                end
            end else begin
                if (a == clr_a) m_dbv = 1'b0;
                if (m_e1[a]) begin
                    if (m_sb != 16'hFFFF) m_sb = m_sb + 16'd1;
                    t.we = 1'b1; t.addr = AW'(a); t.wdata = mem_data[a];
                    exp_q.push_back(t);
                    m_e1[a] = 1'b0;
                end
            end
            if (a == D - 1) m_pd++;
            m_addr = (a + 1) % D;
        end
    endfunction

    // index of first differing transaction, -1 if the logs agree
    function automatic int log_mismatch();
        int n;
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (log_q[i].we !== exp_q[i].we || log_q[i].addr !== exp_q[i].addr) return i;
            if (exp_q[i].we && log_q[i].wdata !== exp_q[i].wdata) return i;
        end
        if (log_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    task automatic load_errs(input logic [D-1:0] e1, input logic [D-1:0] e2);
        for (int a = 0; a < D; a++) begin
            mem_e1[a] = e1[a];
            m_e1[a]   = e1[a];
            mem_e2[a] = e2[a];
        end
    endtask

    // enable, let n reads be granted, then drop enable and wait for IDLE
    task automatic run_words(input int n, input int clr_a, output bit timed_out);
        int target, t;
        log_q.delete(); exp_q.delete(); grant_cyc.delete();
        predict(n, clr_a);
        clr_at    = clr_a;
        target    = rd_cnt + n;
        timed_out = 1'b0;
        @(negedge clk); #1;
        en = 1'b1;
        t  = 0;
        while (rd_cnt < target && t < TMO) begin @(negedge clk); #1; t++; end
        en = 1'b0;
        while (busy !== 1'b0 && t < TMO) begin @(negedge clk); #1; t++; end
        if (t >= TMO) timed_out = 1'b1;
        repeat (3) @(negedge clk);
        clr_at = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; interval = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({mem_req, mem_we, busy, pass_done, db_valid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 00000", {mem_req, mem_we, busy, pass_done, db_valid});
        end
        tests_run++;
        if ({mem_addr, mem_wdata, db_addr} !== '0) begin
            tests_failed++;
            $display("FAIL reset_addr: got addr=%0h wdata=%0h db_addr=%0h expected 0", mem_addr, mem_wdata, db_addr);
        end
        tests_run++;
        if (sb_count !== 16'h0 || db_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_counts: got sb=%0h db=%0h expected 0", sb_count, db_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_clean_pass();
        bit to; int pd0, mpd0, mm;
        load_errs('0, '0);
        gdly = 0; rdly = 0; noise = 0; interval = '0;
        pd0 = pd_cnt; mpd0 = m_pd;
        run_words(4, -1, to);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL clean_timeout: got timeout expected idle"); end
        mm = log_mismatch();
        tests_run++;
        if (mm !== -1) begin
            tests_failed++;
            $display("FAIL clean_log: got mismatch at %0d (size %0d) expected size %0d", mm, log_q.size(), exp_q.size());
        end
        tests_run++;
        if (grant_cyc.size() !== 4) begin
            tests_failed++;
            $display("FAIL clean_reads: got %0d expected 4", grant_cyc.size());
        end
        for (int i = 1; i < grant_cyc.size(); i++) begin
            tests_run++;
            if (grant_cyc[i] - grant_cyc[i-1] !== 4) begin
                tests_failed++;
                $display("FAIL clean_spacing: got %0d cycles expected 4", grant_cyc[i] - grant_cyc[i-1]);
            end
        end
        tests_run++;
        if (pd_cnt - pd0 !== m_pd - mpd0) begin
            tests_failed++;
            $display("FAIL clean_pass_done: got %0d pulses expected %0d", pd_cnt - pd0, m_pd - mpd0);
        end
    endtask

    task automatic test_interval();
        bit to;
        load_errs('0, '0);
        interval = IW'(3);
        run_words(3, -1, to);
        tests_run++;
        if (to || grant_cyc.size() !== 3) begin
            tests_failed++;
            $display("FAIL interval_reads: got %0d expected 3", grant_cyc.size());
        end
        for (int i = 1; i < grant_cyc.size(); i++) begin
            tests_run++;
            if (grant_cyc[i] - grant_cyc[i-1] !== 7) begin
                tests_failed++;
                $display("FAIL interval_spacing: got %0d cycles expected 7", grant_cyc[i] - grant_cyc[i-1]);
            end
        end
        interval = '0;
        // return the pointer to address 0 for the tests that follow
        run_words((D - m_addr) % D == 0 ? D : (D - m_addr) % D, -1, to);
    endtask

    task automatic test_writeback();
        bit to; int mm, s0;
        load_errs(4'b0100, '0);
        mem_data[2] = 8'hA5;
        gdly = 3;
        s0 = stab_err;
        run_words(4, -1, to);
        mm = log_mismatch();
        tests_run++;
        if (to || mm !== -1) begin
            tests_failed++;
            $display("FAIL wb_log: got mismatch at %0d timeout=%0d expected none", mm, to);
        end
        tests_run++;
        if (stab_err !== s0) begin
            tests_failed++;
            $display("FAIL wb_stable: got %0d changes while waiting expected 0", stab_err - s0);
        end
        tests_run++;
        if (sb_count !== m_sb) begin
            tests_failed++;
            $display("FAIL wb_sb_count: got %0h expected %0h", sb_count, m_sb);
        end
        gdly = 0;
    endtask

    task automatic test_double();
        bit to; int mm;
        load_errs('0, 4'b1010);
        run_words(4, -1, to);
        mm = log_mismatch();
        tests_run++;
        if (to || mm !== -1) begin
            tests_failed++;
            $display("FAIL db_log: got mismatch at %0d timeout=%0d expected none", mm, to);
        end
        tests_run++;
        if (db_count !== m_db || db_valid !== m_dbv || int'(db_addr) !== m_dba) begin
            tests_failed++;
            $display("FAIL db_first: got cnt=%0d v=%0d a=%0d expected cnt=%0d v=%0d a=%0d",
                     db_count, db_valid, db_addr, m_db, m_dbv, m_dba);
        end
        run_words(4, 3, to);
        tests_run++;
        if (db_count !== m_db || db_valid !== m_dbv || int'(db_addr) !== m_dba) begin
            tests_failed++;
            $display("FAIL db_clr_capture: got cnt=%0d v=%0d a=%0d expected cnt=%0d v=%0d a=%0d",
                     db_count, db_valid, db_addr, m_db, m_dbv, m_dba);
        end
        @(negedge clk); #1;
        clr_force = 1'b1;
        repeat (2) @(negedge clk);
        #1 clr_force = 1'b0;
        m_dbv = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (db_valid !== m_dbv) begin
            tests_failed++;
            $display("FAIL db_clr_alone: got valid=%0d expected %0d", db_valid, m_dbv);
        end
    endtask

    task automatic test_en_low();
        bit to; int mm; logic [D-1:0] e1;
        e1 = '0;
        e1[(m_addr + 1) % D] = 1'b1;
        load_errs(e1, '0);
        gdly = 1; rdly = 1;
        run_words(2, -1, to);
        mm = log_mismatch();
        tests_run++;
        if (to || mm !== -1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_low_wb: got mismatch at %0d busy=%0d expected none, busy=0", mm, busy);
        end
        run_words(1, -1, to);
        tests_run++;
        if (to || log_q.size() < 1 || int'(log_q[0].addr) !== exp_q[0].addr || log_q[0].we !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_low_resume: got %0d reads, first addr %0d expected addr %0d",
                     log_q.size(), (log_q.size() > 0) ? int'(log_q[0].addr) : -1, exp_q[0].addr);
        end
        gdly = 0; rdly = 0;
    endtask

    task automatic test_saturate();
        bit to;
        load_errs(4'b0011, 4'b0100);
        @(negedge clk);
        force dut.o_sb_count = 16'hFFFE;
        force dut.o_db_count = 16'hFFFF;
        #1;
        release dut.o_sb_count;
        release dut.o_db_count;
        m_sb = 16'hFFFE; m_db = 16'hFFFF;
        run_words(4, -1, to);
        tests_run++;
        if (to || sb_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_sb: got %0h expected ffff", sb_count);
        end
        tests_run++;
        if (db_count !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_db: got %0h expected ffff", db_count);
        end
    endtask

    task automatic test_random();
        bit to; int mm, pd0, mpd0, clr_a;
        noise = 1'b1;
        for (int it = 0; it < 8; it++) begin
            for (int a = 0; a < D; a++) begin
                mem_data[a] = K'($urandom);
                mem_e1[a]   = ($urandom_range(0, 2) == 0);
                m_e1[a]     = mem_e1[a];
                mem_e2[a]   = ($urandom_range(0, 3) == 0);
            end
            gdly = $urandom_range(0, 3);
            rdly = $urandom_range(0, 2);
            interval = IW'($urandom_range(0, 3));
            clr_a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, D - 1) : -1;
            pd0 = pd_cnt; mpd0 = m_pd;
            run_words($urandom_range(3, 9), clr_a, to);
            mm = log_mismatch();
            tests_run++;
            if (to || mm !== -1) begin
                tests_failed++;
                $display("FAIL rand_log[%0d]: got mismatch at %0d timeout=%0d expected none", it, mm, to);
            end
            tests_run++;
            if (sb_count !== m_sb || db_count !== m_db || db_valid !== m_dbv ||
                (m_dbv && int'(db_addr) !== m_dba) || pd_cnt - pd0 !== m_pd - mpd0) begin
                tests_failed++;
                $display("FAIL rand_state[%0d]: got sb=%0h db=%0h v=%0d a=%0d pd=%0d expected sb=%0h db=%0h v=%0d a=%0d pd=%0d",
                         it, sb_count, db_count, db_valid, db_addr, pd_cnt - pd0, m_sb, m_db, m_dbv, m_dba, m_pd - mpd0);
            end
        end
        noise = 1'b0; interval = '0; gdly = 0; rdly = 0;
    endtask

    task automatic test_async_reset();
        bit to; int t;
        load_errs('0, '0);
        gdly = 50;
        @(negedge clk); #1;
        en = 1'b1;
        t = 0;
        while (mem_req !== 1'b1 && t < 100) begin @(negedge clk); #1; t++; end
        tests_run++;
        if (mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_req_seen: got %0d expected 1", mem_req);
        end
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_req: got req=%0d busy=%0d expected 0 0", mem_req, busy);
        end
        tests_run++;
        if (sb_count !== 16'h0 || db_count !== 16'h0 || db_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_counts: got sb=%0h db=%0h v=%0d expected 0", sb_count, db_count, db_valid);
        end
        en = 1'b0;
        gdly = 0;
        m_addr = 0; m_sb = 0; m_db = 0; m_dbv = 0; m_dba = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_words(1, -1, to);
        tests_run++;
        if (to || log_q.size() !== 1 || log_q[0].addr !== AW'(0)) begin
            tests_failed++;
            $display("FAIL areset_restart: got %0d txns timeout=%0d expected 1 read at addr 0", log_q.size(), to);
        end
    endtask

    initial begin
        for (int a = 0; a < D; a++) mem_data[a] = K'(a * 37 + 5);
        test_reset();
        test_clean_pass();
        test_interval();
        test_writeback();
        test_double();
        test_en_low();
        test_saturate();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
